// File: rtl/seq_shift_add_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, valid/ready on both sides.
// Define SEQ_MULT_SIGNED_EN to honour is_signed (two's-complement mode) per operation.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   mcand, mplier, mplier_n;
  logic [WIDTH-1:0]   mcand_in, mplier_in;
  logic [WIDTH:0]     acc, sum, acc_n;
  logic [CW-1:0]      cnt;
  logic               last;
  logic [2*WIDTH-1:0] product, result;

  // One shift-add step: the product's low half builds up in mplier as its bits shift out.
  assign sum      = acc + {1'b0, (mplier[0] ? mcand : '0)};
  assign acc_n    = {1'b0, sum[WIDTH:1]};
  assign mplier_n = {sum[0], mplier[WIDTH-1:1]};
  assign product  = {acc_n[WIDTH-1:0], mplier_n};
  assign last     = (cnt == CW'(WIDTH - 1));

`ifdef SEQ_MULT_SIGNED_EN
  logic neg, neg_in;

  // Magnitudes fit WIDTH unsigned bits, including 2^(WIDTH-1) for the most-negative value.
  assign mcand_in  = (is_signed && in1[WIDTH-1]) ? (~in1 + 1'b1) : in1;
  assign mplier_in = (is_signed && in2[WIDTH-1]) ? (~in2 + 1'b1) : in2;
  assign neg_in    = is_signed & (in1[WIDTH-1] ^ in2[WIDTH-1]);
  assign result    = neg ? (~product + 1'b1) : product;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          neg <= 1'b0;
    else if (state == IDLE && in_valid)  neg <= neg_in;
  end
`else
  logic unused_is_signed;

  assign unused_is_signed = is_signed;
  assign mcand_in         = in1;
  assign mplier_in        = in2;
  assign result           = product;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    // NOTE: default first so every path assigns state_n and no latch is inferred.
    state_n = state;
    case (state)
      IDLE:    if (in_valid)  state_n = CALC;
      CALC:    if (last)      state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      out    <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= mcand_in;
          mplier <= mplier_in;
          acc    <= '0;
          cnt    <= '0;
        end
        CALC: begin
          acc    <= acc_n;
          mplier <= mplier_n;
          cnt    <= cnt + 1'b1;
          if (last) out <= result;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench for seq_shift_add_multiplier (WIDTH=8) against an arithmetic model.
module tb_seq_shift_add_multiplier;

  localparam int W   = 8;
  localparam int LIM = 50;
`ifdef SEQ_MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid, in_ready, is_signed, out_valid, out_ready, busy;
  logic [W-1:0]   in1, in2;
  logic [2*W-1:0] out;

  int n_checks = 0;
  int n_fail   = 0;

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .is_signed(is_signed), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit s);
    int p;
    if (SIGNED_EN && s) begin
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      p  = sa * sb;
    end else begin
      p = int'(a) * int'(b);
    end
    return p[2*W-1:0];
  endfunction

  // Drives one operation; returns the product and the edge count from accept to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input bit ack, output logic [2*W-1:0] res, output int lat);
    @(negedge clk);
    in1 = a; in2 = b; is_signed = s; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; is_signed = ~s; in1 = ~a; in2 = ~b;
    lat = 0;
    while (!out_valid && lat < LIM) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = out;
    if (ack && out_valid) begin
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic check_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit s, input logic [2*W-1:0] exp);
    logic [2*W-1:0] res;
    int lat;
    run_op(a, b, s, 1'b1, res, lat);
    n_checks++;
    if (res !== exp) begin
      n_fail++;
      $display("FAIL %s: out=%h expected %h", name, res, exp);
    end
    n_checks++;
    if (lat !== W) begin
      n_fail++;
      $display("FAIL %s latency: %0d cycles expected %0d", name, lat, W);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; is_signed = 1'b0; in1 = '0; in2 = '0;
    #12;
    n_checks++;
    if ({in_ready, out_valid, busy, out} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset: rdy/vld/busy/out=%b/%b/%b/%h expected 1/0/0/0000",
               in_ready, out_valid, busy, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    check_op("unsigned_200x150", 8'd200, 8'd150, 1'b0, 16'h7530);
  endtask

  task automatic test_signed();
    check_op("signed_m128xm128", 8'h80, 8'h80, 1'b1, SIGNED_EN ? 16'h4000 : 16'h4000);
    check_op("signed_m3x5", 8'hFD, 8'h05, 1'b1, SIGNED_EN ? 16'hFFF1 : 16'h04F1);
    check_op("unsigned_FDx05", 8'hFD, 8'h05, 1'b0, 16'h04F1);
    check_op("signed_m128x127", 8'h80, 8'h7F, 1'b1, model(8'h80, 8'h7F, 1'b1));
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      logic [W-1:0] a, b;
      bit s;
      a = W'($urandom); b = W'($urandom); s = 1'($urandom);
      check_op($sformatf("random_%0d", i), a, b, s, model(a, b, s));
    end
  endtask

  task automatic test_zero();
    check_op("zero_00xAB", 8'h00, 8'hAB, 1'b0, 16'h0000);
    check_op("zero_ABx00_signed", 8'hAB, 8'h00, 1'b1, 16'h0000);
  endtask

  task automatic test_back_pressure();
    logic [2*W-1:0] res;
    int lat;
    run_op(8'h9C, 8'h37, 1'b0, 1'b0, res, lat);
    n_checks++;
    if (res !== model(8'h9C, 8'h37, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_result: out=%h expected %h", res, model(8'h9C, 8'h37, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in1 = W'($urandom); in2 = W'($urandom);
      @(posedge clk);
      #1;
      n_checks++;
      if ({out, out_valid, in_ready, busy} !== {res, 1'b1, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: out/vld/rdy/busy=%h/%b/%b/%b expected %h/1/0/1",
                 i, out, out_valid, in_ready, busy, res);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if ({out_valid, in_ready, busy, out} !== {1'b0, 1'b1, 1'b0, res}) begin
      n_fail++;
      $display("FAIL bp_release: vld/rdy/busy/out=%b/%b/%b/%h expected 0/1/0/%h",
               out_valid, in_ready, busy, out, res);
    end
    check_op("bp_after", 8'h11, 8'h22, 1'b0, 16'h0242);
  endtask

  task automatic test_reset_mid_calc();
    @(negedge clk);
    in1 = 8'hC3; in2 = 8'h5A; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, busy, in_ready, out} !== {1'b0, 1'b0, 1'b1, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid_calc: vld/busy/rdy/out=%b/%b/%b/%h expected 0/0/1/0000",
               out_valid, busy, in_ready, out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_op("after_reset_FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] exp_q[$];
    int prev_acc = -1;
    int n_acc = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 70; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_unexpected: out=%h with nothing outstanding", out);
        end else if (out !== exp_q[0]) begin
          n_fail++;
          $display("FAIL b2b_result: out=%h expected %h", out, exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      in_valid = (cyc < 55);
      in1 = W'($urandom); in2 = W'($urandom); is_signed = 1'($urandom);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in1, in2, is_signed));
        if (prev_acc >= 0) begin
          n_checks++;
          if (cyc - prev_acc !== W + 2) begin
            n_fail++;
            $display("FAIL b2b_period: %0d cycles expected %0d", cyc - prev_acc, W + 2);
          end
        end
        prev_acc = cyc;
        n_acc++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0 || n_acc < 4) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d left, %0d accepted (expected 0 left, >=4 accepted)",
               exp_q.size(), n_acc);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_random();
    test_back_pressure();
    test_reset_mid_calc();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
